// File: rtl/reg_wb_pkg.sv
// Shared types for the register writeback arbiter: write request payload and issue-source tags.
package reg_wb_pkg;

    localparam int unsigned WB_AWIDTH = 3;
    localparam int unsigned WB_DWIDTH = 8;

    typedef struct packed {
        logic [WB_AWIDTH-1:0] waddr;
        logic [WB_DWIDTH-1:0] wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_LSU,
        WB_SRC_DROP
    } wb_src_e;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// ALU/load result handshakes and register-bank write port; REG_WB_FWD_EN adds decode forwarding signals.
interface reg_writeback_arbiter_if #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 8
) ();
    logic              alu_valid;
    logic              alu_ready;
    logic [AWIDTH-1:0] alu_waddr;
    logic [DWIDTH-1:0] alu_wdata;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [AWIDTH-1:0] lsu_waddr;
    logic [DWIDTH-1:0] lsu_wdata;
    logic              wen;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;
    logic              pending;
`ifdef REG_WB_FWD_EN
    logic [AWIDTH-1:0] raddr1;
    logic [AWIDTH-1:0] raddr2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DWIDTH-1:0] fwd1_data;
    logic [DWIDTH-1:0] fwd2_data;
`endif

`ifdef REG_WB_FWD_EN
    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata, raddr1, raddr2,
        output alu_ready, lsu_ready, wen, waddr, wdata, pending, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
    modport master (
        output alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata, raddr1, raddr2,
        input  alu_ready, lsu_ready, wen, waddr, wdata, pending, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
`else
    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata,
        output alu_ready, lsu_ready, wen, waddr, wdata, pending
    );
    modport master (
        output alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata,
        input  alu_ready, lsu_ready, wen, waddr, wdata, pending
    );
`endif
endinterface

// File: rtl/reg_wb_fifo.sv
// Load-result queue with per-entry live bit; an address-match kill retires stale loads in place.
module reg_wb_fifo #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [AWIDTH-1:0] push_waddr_i,
    input  logic [DWIDTH-1:0] push_wdata_i,
    input  logic              pop_i,
    input  logic              kill_en_i,
    input  logic [AWIDTH-1:0] kill_addr_i,
    output logic              head_valid_o,
    output logic              head_live_o,
    output logic [AWIDTH-1:0] head_waddr_o,
    output logic [DWIDTH-1:0] head_wdata_o,
    output logic              any_live_o,
    output logic              ready_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [AWIDTH-1:0] waddr_q [DEPTH];
    logic [DWIDTH-1:0] wdata_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q;

    // Kill first, then pop retires the head, then a push (itself subject to the kill) lands at the tail.
    always_comb begin
        live_d = live_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_en_i && waddr_q[PW'(i)] == kill_addr_i) live_d[PW'(i)] = 1'b0;
        end
        if (pop_i)  live_d[rd_ptr_q] = 1'b0;
        if (push_i) live_d[wr_ptr_q] = !(kill_en_i && push_waddr_i == kill_addr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                waddr_q[PW'(i)] <= '0;
                wdata_q[PW'(i)] <= '0;
            end
        end else begin
            live_q  <= live_d;
            count_q <= CW'(count_q + CW'(push_i) - CW'(pop_i));
            if (pop_i) rd_ptr_q <= PW'(rd_ptr_q + PW'(1));
            if (push_i) begin
                waddr_q[wr_ptr_q] <= push_waddr_i;
                wdata_q[wr_ptr_q] <= push_wdata_i;
                wr_ptr_q          <= PW'(wr_ptr_q + PW'(1));
            end
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_live_o  = head_valid_o && live_q[rd_ptr_q];
    assign head_waddr_o = waddr_q[rd_ptr_q];
    assign head_wdata_o = wdata_q[rd_ptr_q];
    assign any_live_o   = |live_q;
    assign ready_o      = (count_q < CW'(DEPTH));
endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and load results onto the register bank write port; REG_WB_FWD_EN adds decode forwarding.
module reg_writeback_arbiter
    import reg_wb_pkg::*;
#(
    parameter int unsigned AWIDTH     = 3,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    reg_writeback_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic              head_valid, head_live, any_live, fifo_ready;
    logic [AWIDTH-1:0] head_waddr;
    logic [DWIDTH-1:0] head_wdata;
    logic              pop, kill_en, push, alu_ready_c;
    wb_src_e           src;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wen_q, wen_d;
    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    assign push = bus.lsu_valid && fifo_ready;

    reg_wb_fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_waddr_i (bus.lsu_waddr),
        .push_wdata_i (bus.lsu_wdata),
        .pop_i        (pop),
        .kill_en_i    (kill_en),
        .kill_addr_i  (bus.alu_waddr),
        .head_valid_o (head_valid),
        .head_live_o  (head_live),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .any_live_o   (any_live),
        .ready_o      (fifo_ready)
    );

    // Priority: starved load, then ALU, then queue head (dead heads drain silently).
    always_comb begin
        src         = WB_SRC_NONE;
        pop         = 1'b0;
        kill_en     = 1'b0;
        alu_ready_c = 1'b1;
        starve_d    = starve_q;
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        if (starve_q == SW'(STARVE_MAX) && head_live) begin
            alu_ready_c = 1'b0;
            pop         = 1'b1;
            src         = WB_SRC_LSU;
            starve_d    = '0;
        end else if (bus.alu_valid) begin
            src     = WB_SRC_ALU;
            kill_en = 1'b1;
            if (!head_live)                          starve_d = '0;
            else if (starve_q != SW'(STARVE_MAX))    starve_d = SW'(starve_q + SW'(1));
        end else if (head_valid) begin
            pop = 1'b1;
            src = head_live ? WB_SRC_LSU : WB_SRC_DROP;
        end

        if (!any_live) starve_d = '0;

        case (src)
            WB_SRC_ALU: begin
                wen_d   = (bus.alu_waddr != '0);
                waddr_d = bus.alu_waddr;
                wdata_d = bus.alu_wdata;
            end
            WB_SRC_LSU: begin
                wen_d   = (head_waddr != '0);
                waddr_d = head_waddr;
                wdata_d = head_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.alu_ready = alu_ready_c;
    assign bus.lsu_ready = fifo_ready;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.pending   = any_live;

`ifdef REG_WB_FWD_EN
    // Decode sees the value the bank commits on this edge.
    assign bus.fwd1_hit  = wen_q && (waddr_q == bus.raddr1) && (waddr_q != '0);
    assign bus.fwd2_hit  = wen_q && (waddr_q == bus.raddr2) && (waddr_q != '0);
    assign bus.fwd1_data = wdata_q;
    assign bus.fwd2_data = wdata_q;
`endif
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed self-checking bench for reg_writeback_arbiter (default build, REG_WB_FWD_EN optional).
module tb_reg_writeback_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    reg_writeback_arbiter_if #(.AWIDTH(3), .DWIDTH(8)) bus ();

    reg_writeback_arbiter #(.AWIDTH(3), .DWIDTH(8), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_waddr = '0;
        bus.alu_wdata = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_waddr = '0;
        bus.lsu_wdata = '0;
    endtask

    task automatic alu(input logic [2:0] a, input logic [7:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_waddr = a;
        bus.alu_wdata = d;
    endtask

    task automatic lsu(input logic [2:0] a, input logic [7:0] d);
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = a;
        bus.lsu_wdata = d;
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [2:0] a, input logic [7:0] d);
        chk({tag, "_wen"}, 32'(bus.wen), 32'(w));
        chk({tag, "_waddr"}, 32'(bus.waddr), 32'(a));
        chk({tag, "_wdata"}, 32'(bus.wdata), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
`ifdef REG_WB_FWD_EN
        bus.raddr1 = '0;
        bus.raddr2 = '0;
`endif
        rst = 1'b1;
        #3;
        chk_wr("reset", 1'b0, 3'd0, 8'h00);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("reset_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick(); tick();
        rst = 1'b0;

        // ALU write, single-cycle latency
        alu(3'd3, 8'h5A);
        #1 chk("alu_ready_idle", 32'(bus.alu_ready), 32'd1);
        tick(); idle();
        chk_wr("alu_wr", 1'b1, 3'd3, 8'h5A);
        tick();
        chk("alu_wr_after", 32'(bus.wen), 32'd0);

        // Load write, two-cycle latency
        lsu(3'd2, 8'h11);
        #1 chk("lsu_ready_empty", 32'(bus.lsu_ready), 32'd1);
        tick(); idle();
        chk("ld_n1_pending", 32'(bus.pending), 32'd1);
        chk("ld_n1_wen", 32'(bus.wen), 32'd0);
        tick();
        chk_wr("ld_n2", 1'b1, 3'd2, 8'h11);
        chk("ld_n2_pending", 32'(bus.pending), 32'd0);
        tick();
        chk("ld_after", 32'(bus.wen), 32'd0);

        // Fill FIFO, third load held until space
        lsu(3'd2, 8'hA1);
        tick();
        lsu(3'd3, 8'hB2); alu(3'd1, 8'hC3);
        tick(); idle();
        lsu(3'd4, 8'hD4);
        #1 chk("full_ready", 32'(bus.lsu_ready), 32'd0);
        chk_wr("full_alu", 1'b1, 3'd1, 8'hC3);
        tick();
        chk("full_ready_next", 32'(bus.lsu_ready), 32'd1);
        chk_wr("full_A", 1'b1, 3'd2, 8'hA1);
        tick(); idle();
        chk_wr("full_B", 1'b1, 3'd3, 8'hB2);
        tick();
        chk_wr("full_C", 1'b1, 3'd4, 8'hD4);
        chk("full_pending", 32'(bus.pending), 32'd0);
        tick();
        chk("full_after", 32'(bus.wen), 32'd0);

        // ALU write kills older queued load to same register
        lsu(3'd5, 8'h77);
        tick(); idle();
        alu(3'd5, 8'h99);
        #1 chk("kill_pending_before", 32'(bus.pending), 32'd1);
        tick(); idle();
        chk_wr("kill_alu", 1'b1, 3'd5, 8'h99);
        chk("kill_pending_after", 32'(bus.pending), 32'd0);
        tick();
        chk_wr("kill_dead_pop", 1'b0, 3'd5, 8'h99);
        tick();
        chk("kill_after", 32'(bus.wen), 32'd0);

        // Starvation: four ALU wins, then one ALU stall for the load
        lsu(3'd6, 8'h66);
        tick(); idle();
        for (int k = 1; k <= 4; k++) begin
            alu(3'd7, 8'(8'h10 + k));
            #1 chk("starve_alu_ready", 32'(bus.alu_ready), 32'd1);
            tick();
            chk_wr("starve_alu_wr", 1'b1, 3'd7, 8'(8'h10 + k));
        end
        alu(3'd7, 8'h15);
        #1 chk("starve_stall", 32'(bus.alu_ready), 32'd0);
        tick();
        chk_wr("starve_load", 1'b1, 3'd6, 8'h66);
        chk("starve_pending", 32'(bus.pending), 32'd0);
        chk("starve_ready_back", 32'(bus.alu_ready), 32'd1);
        tick(); idle();
        chk_wr("starve_alu_last", 1'b1, 3'd7, 8'h15);
        tick();

        // Writes to x0 suppressed
        alu(3'd0, 8'hEE);
        tick(); idle();
        chk_wr("x0_alu", 1'b0, 3'd0, 8'hEE);
        lsu(3'd0, 8'h33);
        tick(); idle();
        chk("x0_ld_pending", 32'(bus.pending), 32'd1);
        tick();
        chk_wr("x0_ld", 1'b0, 3'd0, 8'h33);
        chk("x0_ld_pending_after", 32'(bus.pending), 32'd0);

        // Reset with two loads queued
        lsu(3'd2, 8'h21);
        tick();
        lsu(3'd3, 8'h31); alu(3'd1, 8'h41);
        tick(); idle();
        chk("rq_ready", 32'(bus.lsu_ready), 32'd0);
        chk("rq_pending", 32'(bus.pending), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_wr("rq_reset", 1'b0, 3'd0, 8'h00);
        chk("rq_reset_pending", 32'(bus.pending), 32'd0);
        chk("rq_reset_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rq_no_write", 32'(bus.wen), 32'd0);
            chk("rq_no_pending", 32'(bus.pending), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
